// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM driver port between instruction fetch and MEM-stage accesses.
// Optional SRAM_ARB_PERF_EN adds per-port wait-cycle counters.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W    = 21,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ack,
    output logic              stall_inst,
    output logic              stall_data,
    output logic              ram_en,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_inst_wait,
    output logic [31:0]       perf_data_wait
`endif
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

    localparam logic [7:0] RdLast = 8'(READ_LAT - 1);
    localparam logic [7:0] WrLast = 8'(WRITE_CYC - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       owner_data;  // current owner; doubles as last_grant (0 = inst)
    logic       grant_data;
    logic       grant_inst;

    assign stall_inst = inst_req & ~inst_ack;
    assign stall_data = data_req & ~data_ack;

    // No grant in an ack cycle: the acked requester has not yet dropped its request.
    assign grant_data = (state == StIdle) & ~inst_ack & ~data_ack & data_req &
                        (~owner_data | ~inst_req);
    assign grant_inst = (state == StIdle) & ~inst_ack & ~data_ack & inst_req & ~grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            owner_data <= 1'b0;
            ram_en     <= 1'b0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
        end else begin
            inst_ack <= 1'b0;
            data_ack <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant_data || grant_inst) begin
                        owner_data <= grant_data;
                        ram_addr   <= grant_data ? data_addr : inst_addr;
                        ram_en     <= 1'b1;
                        cnt        <= '0;
                        if (grant_data && data_we) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= data_wdata;
                            state     <= StWr;
                        end else begin
                            ram_re <= 1'b1;
                            state  <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (cnt == RdLast) begin
                        if (owner_data) begin
                            data_rdata <= ram_rdata;
                            data_ack   <= 1'b1;
                        end else begin
                            inst_rdata <= ram_rdata;
                            inst_ack   <= 1'b1;
                        end
                        ram_en <= 1'b0;
                        ram_re <= 1'b0;
                        state  <= StIdle;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StWr: begin
                    // Single-cycle driver write pulse; address and data stay put.
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (cnt >= WrLast && ram_ack) begin
                        data_ack <= 1'b1;
                        state    <= StIdle;
                    end else if (cnt < WrLast) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic inst_blocked;
    logic data_blocked;

    assign inst_blocked = stall_inst &
                          ((state != StIdle) ? owner_data : (grant_data | data_ack));
    assign data_blocked = stall_data &
                          ((state != StIdle) ? ~owner_data : (grant_inst | inst_ack));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_wait <= '0;
            perf_data_wait <= '0;
        end else begin
            if (inst_blocked && perf_inst_wait != 32'hFFFF_FFFF) begin
                perf_inst_wait <= perf_inst_wait + 32'd1;
            end
            if (data_blocked && perf_data_wait != 32'hFFFF_FFFF) begin
                perf_data_wait <= perf_data_wait + 32'd1;
            end
        end
    end
`endif

endmodule
